// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, opcodes and widths for the SPI master.
package spi_pkg;
    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {IDLE, START, SHIFT, TURN, RECV, STOP} state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_master_shifter.sv
// spi_master_shifter: PISO command register, SIPO receive register and down-counter.
module spi_master_shifter #(
    parameter int TX_W = 10,
    parameter int RX_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [TX_W-1:0] din,
    input  logic            shift_tx,
    input  logic            shift_rx,
    input  logic            miso,
    input  logic            cnt_load,
    input  logic [3:0]      cnt_val,
    output logic            tx_msb,
    output logic [RX_W-1:0] rx_next,
    output logic            cnt_zero
);
    logic [TX_W-1:0] tx;
    logic [RX_W-2:0] rx;
    logic [3:0]      cnt;

    assign tx_msb   = tx[TX_W-1];
    assign rx_next  = {rx, miso};
    assign cnt_zero = cnt == 4'd0;

    // counter saturates at zero so it never wraps inside a state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx  <= '0;
            rx  <= '0;
            cnt <= '0;
        end else begin
            if (load) tx <= din;
            else if (shift_tx) tx <= {tx[TX_W-2:0], 1'b0};
            if (shift_rx) rx <= rx_next[RX_W-2:0];
            if (cnt_load) cnt <= cnt_val;
            else if (!cnt_zero) cnt <= cnt - 4'd1;
        end
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: command-frame SPI master; opcode 11 adds a turnaround and 8-bit receive phase.
// Define SPI_MASTER_SEQ_CHECK_EN to add the sticky seq_err output for out-of-order opcodes.
module spi_master #(
    parameter int TURNAROUND = 2,
    parameter int CMD_W      = spi_pkg::CMD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CMD_W-1:0]           cmd,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    output logic                       SS_n,
    output logic                       MOSI,
    input  logic                       MISO,
    output logic [spi_pkg::DATA_W-1:0] rd_data,
    output logic                       rd_valid
`ifdef SPI_MASTER_SEQ_CHECK_EN
    ,
    output logic                       seq_err
`endif
);
    import spi_pkg::*;

    state_t            state, state_nx;
    logic              rdy_en, accept, shift_tx, shift_rx, cnt_load, cnt_zero, tx_msb, rx_done;
    logic [1:0]        op, cmd_op;
    logic [3:0]        cnt_val;
    logic [DATA_W-1:0] rx_next;

    assign cmd_op    = cmd[CMD_W-1 -: 2];
    assign cmd_ready = rdy_en && state == IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign SS_n      = state == IDLE || state == STOP;
    assign MOSI      = state == SHIFT ? tx_msb : 1'b0;
    assign rx_done   = state == RECV && cnt_zero;

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_val  = 4'd0;
        shift_tx = 1'b0;
        shift_rx = 1'b0;
        case (state)
            IDLE:  state_nx = accept ? START : IDLE;
            START: begin
                state_nx = SHIFT;
                cnt_load = 1'b1;
                cnt_val  = 4'(CMD_W - 1);
            end
            SHIFT: begin
                shift_tx = 1'b1;
                if (cnt_zero) begin
                    state_nx = op == OP_RD_DATA ? TURN : STOP;
                    cnt_load = op == OP_RD_DATA;
                    cnt_val  = 4'(TURNAROUND - 1);
                end
            end
            TURN: begin
                if (cnt_zero) begin
                    state_nx = RECV;
                    cnt_load = 1'b1;
                    cnt_val  = 4'(DATA_W - 1);
                end
            end
            RECV: begin
                shift_rx = 1'b1;
                state_nx = cnt_zero ? STOP : RECV;
            end
            STOP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // rdy_en keeps cmd_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rdy_en   <= 1'b0;
            op       <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            rdy_en   <= 1'b1;
            rd_valid <= rx_done;
            if (accept) op <= cmd_op;
            if (rx_done) rd_data <= rx_next;
        end
    end

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic seen_wa, seen_ra;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_wa <= 1'b0;
            seen_ra <= 1'b0;
            seq_err <= 1'b0;
        end else if (accept) begin
            seen_wa <= seen_wa || cmd_op == OP_WR_ADDR;
            seen_ra <= seen_ra || cmd_op == OP_RD_ADDR;
            seq_err <= seq_err || (cmd_op == OP_RD_DATA && !seen_ra) || (cmd_op == OP_WR_DATA && !seen_wa);
        end
    end
`endif

    spi_master_shifter #(.TX_W(CMD_W), .RX_W(DATA_W)) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .din      (cmd),
        .shift_tx (shift_tx),
        .shift_rx (shift_rx),
        .miso     (MISO),
        .cnt_load (cnt_load),
        .cnt_val  (cnt_val),
        .tx_msb   (tx_msb),
        .rx_next  (rx_next),
        .cnt_zero (cnt_zero)
    );
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001: Parameter TURNAROUND, default 2: idle cycles between the last MOSI bit and the first MISO sample of a read-data frame. Legal range 1..15.
REQ-002: Parameter CMD_W, default 10: command frame width (2 opcode bits + 8 payload bits).
REQ-003: clk, input, 1: single clock; all state changes on its rising edge.
REQ-004: rst_n, input, 1: asynchronous, active-low reset.
REQ-005: cmd, input, 10: bits [9:8] are the opcode (00 write address, 01 write data, 10 read address, 11 read data); bits [7:0] are the payload.
REQ-006: cmd_valid, input, 1: cmd is presented.
REQ-007: cmd_ready, output, 1: the block accepts cmd this cycle.
REQ-008: SS_n, output, 1: slave select, active low.
REQ-009: MOSI, output, 1: serial command data, MSB first.
REQ-010: MISO, input, 1: serial read data, MSB first.
REQ-011: rd_data, output, 8: last byte received.
REQ-012: rd_valid, output, 1: one-cycle pulse when rd_data has been updated.

Function
REQ-013: States SHALL be IDLE, START, SHIFT, TURN, RECV and STOP.
REQ-014: cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle N where cmd_valid and cmd_ready are both 1.
REQ-015: While cmd_ready is 0, cmd_valid SHALL be ignored; no queuing.
REQ-016: On acceptance, cmd SHALL be latched into a 10-bit shift register and the next state is START.
REQ-017: START (cycle N+1): SS_n=0, MOSI=0; the next state is SHIFT.
REQ-018: SHIFT (cycles N+2..N+11): MOSI SHALL carry cmd[9] down to cmd[0], one bit per cycle; SS_n stays 0.
REQ-019: After SHIFT, opcode 11 SHALL go to TURN; every other opcode SHALL go to STOP.
REQ-020: TURN SHALL last exactly TURNAROUND cycles, with SS_n=0 and MOSI=0.
REQ-021: RECV SHALL last 8 cycles; MISO is sampled on each rising edge, MSB first.
REQ-022: The first cycle after RECV SHALL be STOP, with rd_data = the sampled byte and rd_valid=1 for exactly that cycle.
REQ-023: STOP SHALL drive SS_n=1 and MOSI=0 for exactly one cycle, then the state returns to IDLE.
- SS_n is therefore high for at least 2 cycles between back-to-back frames.
REQ-024: Frame length SHALL be 12 cycles for opcodes 00, 01 and 10.
REQ-025: Frame length SHALL be 12+TURNAROUND+8 cycles for opcode 11.
REQ-026: rd_data SHALL hold its value until the next read-data frame completes.
REQ-027: The bit counter SHALL be 4 bits wide and reload at each state entry; it SHALL NOT wrap within a state.

Reset
REQ-028: While rst_n=0, the block SHALL hold: state=IDLE, SS_n=1, MOSI=0, rd_data=0, rd_valid=0, cmd_ready=0, shift register and counter cleared.
REQ-029: Reset asserted mid-frame SHALL abort the frame immediately, with SS_n high in the same cycle as reset assertion; no rd_valid is issued.
REQ-030: cmd_ready SHALL first rise on the first clock edge after rst_n deasserts.

Configuration
REQ-031: Macro SPI_MASTER_SEQ_CHECK_EN, when defined, SHALL add output seq_err (1 bit, reset 0).
- seq_err is set when an opcode-11 command is accepted with no opcode-10 command accepted since reset.
- seq_err is also set when an opcode-01 command is accepted with no opcode-00 command accepted since reset.
- The offending frame is still transmitted.
- seq_err is sticky until reset.
REQ-032: Without SPI_MASTER_SEQ_CHECK_EN, the seq_err port and its tracking flops SHALL be absent; all other behaviour is identical.

Structure
REQ-033: Shared package spi_pkg SHALL hold:
- the state enum;
- the opcode constants OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA;
- CMD_W=10 and DATA_W=8.
REQ-034: One sub-module, spi_master_shifter (a loadable parallel-in/serial-out and serial-in/parallel-out register with counter), SHALL be instantiated once; the FSM stays in spi_master.

Verification
REQ-035: Accept cmd=10'h02A at cycle N -> SS_n low N+1..N+11; MOSI = 0,0,0,0,1,0,1,0,1,0 on N+2..N+11; SS_n high at N+12; no rd_valid.
REQ-036: cmd=10'h3FF, TURNAROUND=2, slave model drives MISO=8'hA5 MSB first during RECV -> rd_data=8'hA5, with a single rd_valid pulse in cycle N+22 together with SS_n=1.
REQ-037: cmd_valid held high with 10'h100 then 10'h1C3 -> second acceptance at N+13; SS_n high during N+12 and N+13; both frames bit-exact.
REQ-038: rst_n pulsed low at N+6 during an opcode-11 frame -> SS_n=1 and MOSI=0 asynchronously; no rd_valid; a new command is accepted on the first edge after release.
REQ-039: With SPI_MASTER_SEQ_CHECK_EN, issue 10'h300 first after reset -> seq_err=1 from N+1 and stays 1; in a separate run, 10'h200 then 10'h300 -> seq_err stays 0.
